decoder_3to8_seq: RTL and testbench

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

---
 rtl/decoder_3to8_seq_if.sv | 32 +++
 rtl/decoder_3to8_seq.sv | 102 ++++++++++
 tb/tb_decoder_3to8_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_seq_if.sv
// Handshake and decoded-output bundle for decoder_3to8_seq.
// The master side presents codes; the slave side (the decoder) accepts them
// and reports the decoded line, status and completion count.
interface decoder_3to8_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic [7:0] dec_count;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  y,
        input  busy,
        input  done,
        input  dec_count
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output y,
        output busy,
        output done,
        output dec_count
    );
endinterface

// File: rtl/decoder_3to8_seq.sv
// Sequential 3-to-8 decoder: each accepted code drives one line of y high
// for HOLD_CYCLES enabled cycles. A one-entry pending buffer lets the next
// code be accepted during a hold, so consecutive codes appear with no gap.
module decoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    decoder_3to8_seq_if.slave  bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] TIMER_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_reg;
    logic [7:0] timer_reg;
    logic       pend_valid_reg;
    logic [2:0] pend_code_reg;
    logic [7:0] y_reg;
    logic       busy_reg;
    logic [7:0] count_reg;

    logic       transfer;
    logic       final_cycle;
    logic [2:0] load_code;
    logic [7:0] load_onehot;

    // Ready only when out of reset, enabled and the pending slot is free.
    assign bus.in_ready  = rst_n & en & ~pend_valid_reg;
    assign transfer      = bus.in_valid & bus.in_ready;
    assign final_cycle   = (state_reg == HOLD) && (timer_reg == 8'd0);
    // done depends on registered state plus en/rst_n only, never in_valid.
    assign bus.done      = rst_n & en & final_cycle;

    // A buffered code always takes precedence over the live input; the
    // pending slot is only ever occupied while holding.
    assign load_code = pend_valid_reg ? pend_code_reg : bus.in_code;

    // One comparator per output line forms the one-hot of the code to load.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign load_onehot[gi] = (load_code == 3'(gi));
        end
    endgenerate

    assign bus.y         = y_reg;
    assign bus.busy      = busy_reg;
    assign bus.dec_count = count_reg;

    // Hold FSM: loads codes, times each hold and chains pending codes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            timer_reg      <= 8'd0;
            pend_valid_reg <= 1'b0;
            pend_code_reg  <= 3'd0;
            y_reg          <= 8'h00;
            busy_reg       <= 1'b0;
            count_reg      <= 8'h00;
        end else if (en) begin
            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        state_reg <= HOLD;
                        y_reg     <= load_onehot;
                        busy_reg  <= 1'b1;
                        timer_reg <= TIMER_RELOAD;
                    end
                end
                HOLD: begin
                    if (timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                        if (transfer) begin
                            pend_valid_reg <= 1'b1;
                            pend_code_reg  <= bus.in_code;
                        end
                    end else begin
                        count_reg <= count_reg + 8'd1;
                        if (pend_valid_reg) begin
                            y_reg          <= load_onehot;
                            timer_reg      <= TIMER_RELOAD;
                            pend_valid_reg <= 1'b0;
                        end else if (transfer) begin
                            // Same-cycle arrival bypasses the buffer.
                            y_reg     <= load_onehot;
                            timer_reg <= TIMER_RELOAD;
                        end else begin
                            state_reg <= IDLE;
                            y_reg     <= 8'h00;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Scoreboard bench for decoder_3to8_seq. Two instances (hold 4 and hold 1)
// share one stimulus stream; each has its own queue of outstanding codes.
module tb_decoder_3to8_seq;

    localparam int H0 = 4;
    localparam int H1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;

    always #5 clk = ~clk;

    decoder_3to8_seq_if bus4 ();
    decoder_3to8_seq_if bus1 ();

    assign bus4.in_valid = in_valid;
    assign bus4.in_code  = in_code;
    assign bus1.in_valid = in_valid;
    assign bus1.in_code  = in_code;

    decoder_3to8_seq #(.HOLD_CYCLES(H0)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus4));
    decoder_3to8_seq #(.HOLD_CYCLES(H1)) dut1 (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus1));

    logic [7:0] y_o   [2];
    logic [7:0] cnt_o [2];
    logic       busy_o[2];
    logic       done_o[2];
    logic       rdy_o [2];

    assign y_o[0] = bus4.y;          assign y_o[1] = bus1.y;
    assign cnt_o[0] = bus4.dec_count; assign cnt_o[1] = bus1.dec_count;
    assign busy_o[0] = bus4.busy;    assign busy_o[1] = bus1.busy;
    assign done_o[0] = bus4.done;    assign done_o[1] = bus1.done;
    assign rdy_o[0] = bus4.in_ready; assign rdy_o[1] = bus1.in_ready;

    // Reference model: codes accepted but not yet completed, in order.
    logic [2:0] exp_q [2][$];
    logic [7:0] exp_cnt [2] = '{8'h00, 8'h00};
    int         hold_ctr[2] = '{0, 0};
    bit         acc_now [2] = '{1'b0, 1'b0};
    logic [2:0] acc_code = 3'd0;
    bit         fin_now [2] = '{1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    // Input side: record which codes each instance should accept this cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            acc_now[i] = rst_n && en && in_valid && (exp_q[i].size() < 2);
        acc_code = in_code;
    end

    // Output monitor: compare every DUT output with the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         n;
            logic [7:0] ey;
            logic       ed;
            n  = exp_q[i].size();
            ey = (n > 0) ? (8'h01 << exp_q[i][0]) : 8'h00;
            ed = rst_n && en && (n > 0) && (hold_ctr[i] == hold_of(i) - 1);
            fin_now[i] = ed;
            chk("in_ready", i, 32'(rdy_o[i]), 32'(rst_n && en && (n < 2)));
            chk("y", i, 32'(y_o[i]), 32'(ey));
            chk("busy", i, 32'(busy_o[i]), 32'(n > 0));
            chk("done", i, 32'(done_o[i]), 32'(ed));
            chk("dec_count", i, 32'(cnt_o[i]), 32'(exp_cnt[i]));
            if (done_o[i] === 1'b1 && n > 0)
                $display("decode inst%0d code=%0d y=%h count=%0d", i, exp_q[i][0], y_o[i], cnt_o[i]);
        end
    end

    // Model state advances on the clock using the flags captured above.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
                exp_cnt[i]  <= 8'h00;
                hold_ctr[i] <= 0;
            end else if (en) begin
                if (fin_now[i]) begin
                    void'(exp_q[i].pop_front());
                    exp_cnt[i]  <= exp_cnt[i] + 8'd1;
                    hold_ctr[i] <= 0;
                end else if (exp_q[i].size() > 0) begin
                    hold_ctr[i] <= hold_ctr[i] + 1;
                end
                if (acc_now[i])
                    exp_q[i].push_back(acc_code);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a code until the hold-4 instance takes it (bounded).
    task automatic send(input logic [2:0] c);
        bit ok;
        int tries;
        ok = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        in_code  = c;
        while (!ok && tries < 64) begin
            @(negedge clk);
            ok = rdy_o[0];
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 3'd0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // Single decode of code 3.
        send(3'd3);
        step(8);

        // Sweep 0..7 back-to-back.
        for (int k = 0; k < 8; k++) send(3'(k));
        step(12);

        // Buffer full: 5, 6, then 1 stalls.
        send(3'd5); send(3'd6); send(3'd1);
        step(14);

        // Enable freeze mid-hold.
        send(3'd2);
        step(1);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(8);

        // Reset mid-hold with a pending code.
        send(3'd7); send(3'd4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(8);

        // Long back-to-back run: wraps dec_count on the hold-1 instance.
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_code = 3'($urandom_range(0, 7));
            step(1);
        end
        in_valid = 1'b0;
        step(10);

        // Random traffic with occasional freezes and resets.
        for (int k = 0; k < 2000; k++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_code  = 3'($urandom_range(0, 7));
            en       = ($urandom_range(0, 9) != 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            step(1);
        end
        in_valid = 1'b0; en = 1'b1; rst_n = 1'b1;
        step(20);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
